spi_reg_bank: RTL

- Word-level command decoder and register bank directly downstream of the SPI slave.
- Consumes each received word and its one-cycle strobe. Decodes read and write transactions.
- Holds control and status registers. Captures thermocouple samples from the conversion path.
- Drives the response word that the SPI slave shifts out on the next transfer.

---
 rtl/spi_reg_bank.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
//   Word-level command decoder and register bank that sits directly behind the
//   SPI slave. Each received word arrives with a one-cycle strobe. A command
//   word selects read or write and a register address. It is followed by one
//   more word: the data for a write, or a dummy word for a read. The response
//   for the next transfer is presented on o_win.
//
//   Register map (ADDR_BITS-wide address):
//     0 ID      read-only, ID_VALUE
//     1 CTRL    read/write, drives o_ctrl
//     2 SAMPLE  read-only, last i_sample seen with i_sample_vld
//     3 COUNT   read-only saturating count of i_sample_vld pulses;
//               any write clears it
//     4 STATUS  bit0 ERR (sticky), bit1 OVR (sticky), bit2 UNREAD;
//               any write clears ERR and OVR
//     5..      invalid: a read returns 0, any access sets ERR
//
//   Optional build macro: SPI_REG_BANK_PARITY_EN
//     When defined, every command word must have even parity (bit WORD_SIZE-2
//     is the parity bit). A bad command is dropped and ERR is set. When the
//     macro is undefined, the parity bit is ignored.
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_sce         SPI chip enable, active low (high = bus idle)
//   i_wout        word received from the SPI slave
//   i_wstb        one-cycle strobe: i_wout valid
//   o_win         response word shifted out by the SPI slave
//   i_sample      conversion result
//   i_sample_vld  one-cycle strobe: i_sample valid
//   o_ctrl        CTRL register contents
// -----------------------------------------------------------------------------
module spi_reg_bank #(
    parameter int                   WORD_SIZE = 16,
    parameter int                   ADDR_BITS = 3,
    parameter logic [WORD_SIZE-1:0] ID_VALUE  = 16'hC0DE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sce,
    input  logic [WORD_SIZE-1:0] i_wout,
    input  logic                 i_wstb,
    output logic [WORD_SIZE-1:0] o_win,
    input  logic [WORD_SIZE-1:0] i_sample,
    input  logic                 i_sample_vld,
    output logic [WORD_SIZE-1:0] o_ctrl
);

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_WDATA = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    localparam logic [ADDR_BITS-1:0] A_ID     = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] A_CTRL   = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] A_SAMPLE = ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] A_COUNT  = ADDR_BITS'(3);
    localparam logic [ADDR_BITS-1:0] A_STATUS = ADDR_BITS'(4);

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [WORD_SIZE-1:0] status_word(
        input logic unread,
        input logic ovr,
        input logic err
    );
        return WORD_SIZE'({unread, ovr, err});
    endfunction

    function automatic logic [WORD_SIZE-1:0] sat_inc(
        input logic [WORD_SIZE-1:0] v
    );
        return (v == '1) ? v : v + WORD_SIZE'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state, state_nxt;
    logic [ADDR_BITS-1:0]   addr_q, addr_nxt;
    logic [WORD_SIZE-1:0]   sample_q, sample_nxt;
    logic [WORD_SIZE-1:0]   count_q, count_nxt;
    logic                   err_q, err_nxt;
    logic                   ovr_q, ovr_nxt;
    logic                   unread_q, unread_nxt;
    logic                   sce_q;
    logic [WORD_SIZE-1:0]   win_nxt;
    logic [WORD_SIZE-1:0]   ctrl_nxt;

    // Command word fields
    logic                   cmd_wr;
    logic [ADDR_BITS-1:0]   cmd_addr;
    logic                   cmd_invalid;
    logic                   parity_ok;
    logic                   sce_rise;
    logic                   abort;
    logic [WORD_SIZE-1:0]   rd_val;

    assign cmd_wr      = i_wout[WORD_SIZE-1];
    assign cmd_addr    = i_wout[ADDR_BITS-1:0];
    assign cmd_invalid = (cmd_addr > A_STATUS);

`ifdef SPI_REG_BANK_PARITY_EN
    // Even parity across the whole command word.
    assign parity_ok = ~(^i_wout);
`else
    assign parity_ok = 1'b1;
`endif

    // Bus going idle in the middle of a two-word transaction kills it. The
    // edge is used rather than the level so that a command arriving while the
    // bus is still idle is not aborted on the following cycle.
    assign sce_rise = i_sce & ~sce_q;
    assign abort    = sce_rise && (state != S_CMD);

    // Read mux, using register values from before this cycle's updates
    always_comb begin
        rd_val = '0;
        case (cmd_addr)
            A_ID:     rd_val = ID_VALUE;
            A_CTRL:   rd_val = o_ctrl;
            A_SAMPLE: rd_val = sample_q;
            A_COUNT:  rd_val = count_q;
            A_STATUS: rd_val = status_word(unread_q, ovr_q, err_q);
            default:  rd_val = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state and register-update logic
    // -------------------------------------------------------------------------
    always_comb begin
        logic cnt_clr;

        state_nxt  = state;
        addr_nxt   = addr_q;
        sample_nxt = sample_q;
        count_nxt  = count_q;
        err_nxt    = err_q;
        ovr_nxt    = ovr_q;
        unread_nxt = unread_q;
        win_nxt    = o_win;
        ctrl_nxt   = o_ctrl;
        cnt_clr    = 1'b0;

        if (abort) begin
            state_nxt = S_CMD;
            err_nxt   = 1'b1;
        end else if (i_wstb) begin
            case (state)
                S_CMD: begin
                    if (!parity_ok) begin
                        err_nxt = 1'b1;
                    end else if (cmd_wr) begin
                        state_nxt = S_WDATA;
                        addr_nxt  = cmd_addr;
                        win_nxt   = i_wout;
                    end else begin
                        state_nxt = S_RDATA;
                        win_nxt   = rd_val;
                        if (cmd_invalid)
                            err_nxt = 1'b1;
                        if (cmd_addr == A_SAMPLE)
                            unread_nxt = 1'b0;
                    end
                end
                S_WDATA: begin
                    state_nxt = S_CMD;
                    case (addr_q)
                        A_CTRL:   ctrl_nxt = i_wout;
                        A_COUNT:  cnt_clr  = 1'b1;
                        A_STATUS: begin
                            err_nxt = 1'b0;
                            ovr_nxt = 1'b0;
                        end
                        A_ID, A_SAMPLE: ;
                        default:  err_nxt  = 1'b1;
                    endcase
                end
                S_RDATA: state_nxt = S_CMD;
                default: state_nxt = S_CMD;
            endcase
        end

        // Sample capture comes after the bus side, so a new sample wins over
        // a SAMPLE-read clear of UNREAD or a STATUS-write clear of OVR.
        if (i_sample_vld) begin
            sample_nxt = i_sample;
            count_nxt  = sat_inc(count_q);
            unread_nxt = 1'b1;
            if (unread_q)
                ovr_nxt = 1'b1;
        end

        // A COUNT clear wins over a simultaneous increment.
        if (cnt_clr)
            count_nxt = '0;

        // In S_CMD the response is STATUS. It is reloaded only after a strobe
        // or while the bus is idle, so it never changes mid-word.
        if ((state_nxt == S_CMD) && (i_sce || i_wstb))
            win_nxt = status_word(unread_nxt, ovr_nxt, err_nxt);
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_CMD;
        else
            state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Register bank and response word
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q   <= '0;
            sample_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            unread_q <= 1'b0;
            sce_q    <= 1'b1;   // treat the bus as idle out of reset
            o_win    <= '0;
            o_ctrl   <= '0;
        end else begin
            addr_q   <= addr_nxt;
            sample_q <= sample_nxt;
            count_q  <= count_nxt;
            err_q    <= err_nxt;
            ovr_q    <= ovr_nxt;
            unread_q <= unread_nxt;
            sce_q    <= i_sce;
            o_win    <= win_nxt;
            o_ctrl   <= ctrl_nxt;
        end
    end

endmodule
